// File: rtl/aes128_round_key_scheduler.sv
// Sequences the AES-128 key expansion engine and caches round keys 0..10 for the cipher datapath.
// Build option: define AES_RKS_INV_ORDER_EN to serve the read port in decryption order.
module aes128_round_key_scheduler (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [127:0] key_in,
    output logic         key_ready,
    output logic         kx_start,
    output logic [127:0] kx_key,
    input  logic [127:0] kx_subkey,
    input  logic [3:0]   kx_cnt,
    input  logic         kx_valid,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_ack,
    output logic [127:0] rk_data,
    output logic         keys_ready,
    output logic         busy,
    output logic [1:0]   fsm_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] EXPAND = 2'd2;
    localparam logic [1:0] READY  = 2'd3;

    logic [1:0]   state;
    logic [127:0] cache [0:10];
    logic         key_accept;
    logic         subkey_write;
    logic         last_round;
    logic         idx_in_range;
    logic [3:0]   cache_idx;
    logic [127:0] lookup;
    logic         serve;

    // Key handshake: a key transfers on any rising edge where key_valid and key_ready are both 1;
    // key_valid may be held or dropped freely while key_ready is 0, nothing is consumed then.
    assign key_accept   = key_valid && key_ready;
    assign key_ready    = (state == IDLE) || (state == READY);
    assign busy         = (state == LOAD) || (state == EXPAND);
    assign fsm_state    = state;

    assign subkey_write = (state == EXPAND) && kx_valid && (kx_cnt >= 4'd1) && (kx_cnt <= 4'd10);
    assign last_round   = subkey_write && (kx_cnt == 4'd10);

    assign idx_in_range = (rk_idx <= 4'd10);

    always_comb begin
        cache_idx = rk_idx;
`ifdef AES_RKS_INV_ORDER_EN
        cache_idx = 4'd10 - rk_idx;
`else
        cache_idx = rk_idx;
`endif
    end

    assign lookup = idx_in_range ? cache[cache_idx] : '0;

    // An accept edge invalidates the cache, so no read is served on that same edge.
    assign serve  = !rk_ack && rk_req && keys_ready && !key_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, READY: if (key_valid) state <= LOAD;
                LOAD:        state <= EXPAND;
                EXPAND:      if (last_round) state <= READY;
                default:     state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kx_start   <= 1'b0;
            kx_key     <= '0;
            keys_ready <= 1'b0;
        end else begin
            kx_start <= key_accept;
            if (key_accept) begin
                kx_key     <= key_in;
                keys_ready <= 1'b0;
            end else if (last_round) begin
                keys_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 11; i++) cache[i] <= '0;
        end else if (key_accept) begin
            cache[0] <= key_in;
        end else if (subkey_write) begin
            cache[kx_cnt] <= kx_subkey;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_ack  <= 1'b0;
            rk_data <= '0;
        end else begin
            rk_ack <= 1'b0;
            if (serve) begin
                rk_ack  <= 1'b1;
                rk_data <= lookup;
            end
        end
    end

endmodule

// File: tb/tb_aes128_round_key_scheduler.sv
// Scoreboard bench for aes128_round_key_scheduler: behavioural expansion engine, AES reference model,
// directed timing/protocol sequences and randomized key loads and reads.
module tb_aes128_round_key_scheduler;

    localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready;
    logic         kx_start;
    logic [127:0] kx_key;
    logic [127:0] kx_subkey;
    logic [3:0]   kx_cnt;
    logic         kx_valid;
    logic         rk_req = 1'b0;
    logic [3:0]   rk_idx = '0;
    logic         rk_ack;
    logic [127:0] rk_data;
    logic         keys_ready;
    logic         busy;
    logic [1:0]   fsm_state;

    int           checks = 0;
    int           failures = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model_key = '0;
    bit           glitch_en = 1'b0;

    aes128_round_key_scheduler dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .kx_start(kx_start), .kx_key(kx_key), .kx_subkey(kx_subkey), .kx_cnt(kx_cnt),
        .kx_valid(kx_valid), .rk_req(rk_req), .rk_idx(rk_idx), .rk_ack(rk_ack), .rk_data(rk_data),
        .keys_ready(keys_ready), .busy(busy), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- AES reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, base, r, s;
        int e;
        inv = 8'h01; base = x; e = 254;
        while (e > 0) begin
            if (e[0]) inv = gmul(inv, base);
            base = gmul(base, base);
            e = e >> 1;
        end
        r = inv; s = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] key, input int rnd);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] model_rd(input logic [127:0] key, input int idx);
        if (idx > 10) return '0;
`ifdef AES_RKS_INV_ORDER_EN
        return round_key(key, 10 - idx);
`else
        return round_key(key, idx);
`endif
    endfunction

    // ---------------- behavioural expansion engine ----------------
    logic         eng_active, eng_bogus;
    logic [3:0]   eng_cnt, bogus_cnt;
    logic [127:0] bogus_data;
    logic [127:0] eng_tab [0:10];

    always @(posedge clk) begin
        if (reset) begin
            eng_active <= 1'b0;
            eng_cnt    <= 4'd0;
            eng_bogus  <= 1'b0;
        end else if (kx_start) begin
            for (int r = 0; r < 11; r++) eng_tab[r] <= round_key(kx_key, r);
            eng_active <= 1'b1;
            eng_cnt    <= 4'd1;
            eng_bogus  <= 1'b0;
        end else if (eng_active) begin
            if (eng_bogus) begin
                eng_bogus <= 1'b0;
            end else if (eng_cnt == 4'd10) begin
                eng_active <= 1'b0;
                eng_cnt    <= 4'd0;
            end else begin
                eng_cnt <= eng_cnt + 4'd1;
                if (glitch_en && $urandom_range(0, 2) == 0) begin
                    eng_bogus  <= 1'b1;
                    bogus_cnt  <= ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(11, 15));
                    bogus_data <= {$urandom(), $urandom(), $urandom(), $urandom()};
                end
            end
        end
    end

    assign kx_valid  = eng_active;
    assign kx_cnt    = eng_bogus ? bogus_cnt : eng_cnt;
    assign kx_subkey = eng_bogus ? bogus_data : eng_tab[eng_cnt];

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic         rst_q = 1'b0;
    logic [127:0] hold_val = '0;
    bit           prev_ack = 1'b0;

    always @(posedge clk) rst_q <= reset;

    always @(negedge clk) begin
        if (rst_q === 1'b1) begin
            hold_val = '0;
            prev_ack = 1'b0;
        end
        if (rk_ack === 1'b1) begin
            check_bit("ack_gap", prev_ack, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: ack with data %h, none expected", rk_data);
            end else begin
                check("rd_data", rk_data, exp_q.pop_front());
            end
            hold_val = rk_data;
        end else begin
            check("rd_hold", rk_data, hold_val);
        end
        prev_ack = (rk_ack === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic accept_key(input logic [127:0] k);
        int n;
        n = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = k;
        while (!key_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit("key_accept", key_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        model_key = k;
    endtask

    // Called at the negedge of T+1; walks T+1..T+12.
    task automatic check_load(input logic [127:0] k);
        check("kx_key", kx_key, k);
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            check_bit("kx_start", kx_start, c == 1);
            check_bit("busy", busy, c <= 11);
            check_bit("keys_ready", keys_ready, c == 12);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!keys_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit("wait_ready", keys_ready, 1'b1);
    endtask

    task automatic read_key(input int idx, input logic [127:0] exp, input int exp_lat, input string name);
        int n;
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        exp_q.push_back(exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rk_ack && n < 300);
        if (!rk_ack) void'(exp_q.pop_back());
        check_int({name, "_lat"}, n, exp_lat);
        rk_req = 1'b0;
    endtask

    task automatic check_idle();
        check_bit("rst_key_ready", key_ready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_keys_ready", keys_ready, 1'b0);
        check_bit("rst_kx_start", kx_start, 1'b0);
        check_bit("rst_rk_ack", rk_ack, 1'b0);
        check("rst_rk_data", rk_data, '0);
        check("rst_kx_key", kx_key, '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [127:0] exp0, exp1, exp10;
    int           idx, gap, lat;
    bit           after_ack;
    logic [127:0] rk;

    initial begin
`ifdef AES_RKS_INV_ORDER_EN
        exp0  = R10;
        exp10 = K0;
        exp1  = model_rd(K0, 1);
`else
        exp0  = K0;
        exp10 = R10;
        exp1  = R1;
`endif
        repeat (3) @(negedge clk);
        check_idle();
        reset = 1'b0;

        // Known-answer load and reads
        accept_key(K0);
        check_load(K0);
        read_key(0, exp0, 1, "rd0");
        @(negedge clk);
        read_key(1, exp1, 1, "rd1");
        @(negedge clk);
        read_key(10, exp10, 1, "rd10");
        @(negedge clk);
        read_key(12, '0, 1, "rd12");
        read_key(15, '0, 2, "rd15_b2b");
        @(negedge clk);

        // Request held high continuously: ack pattern 1,0,1,0,...
        idx = $urandom_range(0, 10);
        rk_req = 1'b1;
        rk_idx = 4'(idx);
        exp_q.push_back(model_rd(K0, idx));
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check_bit("burst_ack", rk_ack, (i % 2) == 0);
            if (rk_ack && i < 6) begin
                idx = $urandom_range(0, 15);
                rk_idx = 4'(idx);
                exp_q.push_back(model_rd(K0, idx));
            end else if (rk_ack) begin
                rk_req = 1'b0;
            end
        end

        // Reload in READY invalidates; a request during expansion stalls until ready
        accept_key(K0);
        check_bit("invalidate", keys_ready, 1'b0);
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = ~K0;
        check_bit("key_ready_busy", key_ready, 1'b0);
        @(negedge clk);
        check_bit("key_ready_busy", key_ready, 1'b0);
        key_valid = 1'b0;
        read_key(5, R5, 10, "stall_rd5");
        check("kx_key_held", kx_key, K0);

        // Reset in the middle of expansion, then a clean reload
        accept_key(K0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle();
        reset = 1'b0;
        accept_key(K0);
        check_load(K0);
        read_key(0, exp0, 1, "rst_rd0");
        @(negedge clk);
        read_key(10, exp10, 1, "rst_rd10");

        // Randomized keys with engine glitches (ignored counter values) and random reads
        glitch_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rk = {$urandom(), $urandom(), $urandom(), $urandom()};
            accept_key(rk);
            wait_ready();
            after_ack = 1'b0;
            for (int r = 0; r < 12; r++) begin
                idx = $urandom_range(0, 15);
                gap = $urandom_range(0, 2);
                lat = (gap == 0 && after_ack) ? 2 : 1;
                repeat (gap) @(negedge clk);
                read_key(idx, model_rd(model_key, idx), lat, "rand_rd");
                after_ack = 1'b1;
            end
        end
        glitch_en = 1'b0;

        repeat (5) @(negedge clk);
        check_int("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
